// File: rtl/sobel_window_gen_if.sv
// Pixel-stream in / 3x3-window out bundle for sobel_window_gen.
// slave = the window generator, master = pixel source plus window consumer.
interface sobel_window_gen_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] pix_i;
    logic              pix_valid_i;
    logic              pix_ready_o;
    logic [DATA_W-1:0] win_0_o;
    logic [DATA_W-1:0] win_1_o;
    logic [DATA_W-1:0] win_2_o;
    logic [DATA_W-1:0] win_3_o;
    logic [DATA_W-1:0] win_4_o;
    logic [DATA_W-1:0] win_5_o;
    logic [DATA_W-1:0] win_6_o;
    logic [DATA_W-1:0] win_7_o;
    logic [DATA_W-1:0] win_8_o;
    logic              win_valid_o;
    logic              win_ready_i;
    logic              frame_done_o;

    modport slave (
        input  pix_i, pix_valid_i, win_ready_i,
        output pix_ready_o,
        output win_0_o, win_1_o, win_2_o, win_3_o, win_4_o,
        output win_5_o, win_6_o, win_7_o, win_8_o,
        output win_valid_o, frame_done_o
    );

    modport master (
        output pix_i, pix_valid_i, win_ready_i,
        input  pix_ready_o,
        input  win_0_o, win_1_o, win_2_o, win_3_o, win_4_o,
        input  win_5_o, win_6_o, win_7_o, win_8_o,
        input  win_valid_o, frame_done_o
    );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 window generator: two line buffers plus a column shifter; window valid 1 clk after
// the accept of its bottom-right pixel; a held window (valid && !ready) stalls the pixel source.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int DATA_W     = 8
) (
    input  logic clk,
    input  logic rst,
    sobel_window_gen_if.slave io
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef logic [DATA_W-1:0] pix_t;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Row r-1 lives in lb1, row r-2 in lb0; contents never reset.
    pix_t lb0_mem [IMG_WIDTH];
    pix_t lb1_mem [IMG_WIDTH];

    // [0..2] = {top,mid,bot} of column c-2, [3..5] = same for column c-1
    logic [5:0][DATA_W-1:0] sh_q, sh_d;
    logic [8:0][DATA_W-1:0] win_q, win_d;

    logic win_valid_q, win_valid_d;
    logic frame_done_q, frame_done_d;

    logic pix_ready;
    logic accept;
    logic emit;
    logic col_last;
    logic row_last;
    pix_t top_rd;
    pix_t mid_rd;

    assign pix_ready = !win_valid_q || io.win_ready_i;
    assign accept    = io.pix_valid_i && pix_ready;
    assign col_last  = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last  = (row_q == RW'(IMG_HEIGHT - 1));
    assign emit      = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign top_rd    = lb0_mem[col_q];
    assign mid_rd    = lb1_mem[col_q];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        sh_d         = sh_q;
        win_d        = win_q;
        frame_done_d = 1'b0;
        win_valid_d  = win_valid_q && !io.win_ready_i;

        if (accept) begin
            sh_d[0] = sh_q[3];
            sh_d[1] = sh_q[4];
            sh_d[2] = sh_q[5];
            sh_d[3] = top_rd;
            sh_d[4] = mid_rd;
            sh_d[5] = io.pix_i;

            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // Load the window as it will look after this accept's shift, row-major.
        if (emit) begin
            win_d[0]    = sh_q[0];
            win_d[1]    = sh_q[3];
            win_d[2]    = top_rd;
            win_d[3]    = sh_q[1];
            win_d[4]    = sh_q[4];
            win_d[5]    = mid_rd;
            win_d[6]    = sh_q[2];
            win_d[7]    = sh_q[5];
            win_d[8]    = io.pix_i;
            win_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            sh_q         <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            sh_q         <= sh_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read-before-write: the combinational reads above see the old row data.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_q] <= lb1_mem[col_q];
            lb1_mem[col_q] <= io.pix_i;
        end
    end

    assign io.pix_ready_o  = pix_ready;
    assign io.win_valid_o  = win_valid_q;
    assign io.frame_done_o = frame_done_q;
    assign io.win_0_o      = win_q[0];
    assign io.win_1_o      = win_q[1];
    assign io.win_2_o      = win_q[2];
    assign io.win_3_o      = win_q[3];
    assign io.win_4_o      = win_q[4];
    assign io.win_5_o      = win_q[5];
    assign io.win_6_o      = win_q[6];
    assign io.win_7_o      = win_q[7];
    assign io.win_8_o      = win_q[8];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image; windows are predicted from the pixel pattern.
module tb_sobel_window_gen;
    localparam int W = 4;
    localparam int H = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_window_gen_if #(.DATA_W(8)) io ();

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_n = 0;
    int first_win_cyc = -1;
    logic [71:0] got_q [$];
    int got_cyc [$];
    int acc_cyc [$];
    int fd_cyc  [$];

    function automatic logic [71:0] cur_win();
        return {io.win_0_o, io.win_1_o, io.win_2_o, io.win_3_o, io.win_4_o,
                io.win_5_o, io.win_6_o, io.win_7_o, io.win_8_o};
    endfunction

    // Pixel at raster index k of a frame whose pattern is base + 16*r + c.
    function automatic logic [7:0] pix_at(input logic [7:0] base, input int k);
        return base + 8'(16 * (k / W) + (k % W));
    endfunction

    // n-th window of a frame in raster order: top-left at (n/(W-2), n%(W-2)).
    function automatic logic [71:0] model_win(input logic [7:0] base, input int n);
        logic [71:0] w;
        int r0;
        int c0;
        r0 = n / (W - 2);
        c0 = n % (W - 2);
        w  = '0;
        for (int i = 0; i < 9; i++)
            w[(8 - i) * 8 +: 8] = base + 8'(16 * (r0 + i / 3) + c0 + i % 3);
        return w;
    endfunction

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
        acc_cyc.delete();
        fd_cyc.delete();
        acc_n = 0;
        first_win_cyc = -1;
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later, log handshakes.
    task automatic cycle(input bit v, input logic [7:0] p, input bit rdy);
        io.pix_valid_i = v;
        io.pix_i       = p;
        io.win_ready_i = rdy;
        #1;
        if (v && io.pix_ready_o) begin
            acc_cyc.push_back(cyc);
            acc_n++;
        end
        if (io.win_valid_o && first_win_cyc < 0) first_win_cyc = cyc;
        if (io.win_valid_o && rdy) begin
            got_q.push_back(cur_win());
            got_cyc.push_back(cyc);
        end
        if (io.frame_done_o) fd_cyc.push_back(cyc);
        @(negedge clk);
        cyc++;
    endtask

    // gap: 0 = valid every cycle, 1 = valid toggles, 2 = random valid.
    task automatic send_frame(input logic [7:0] base, input int gap, input bit rnd_rdy, input bit drain);
        int n0;
        int budget;
        bit v;
        bit phase;
        n0 = acc_n;
        budget = 400;
        phase = 1'b1;
        while (acc_n - n0 < NPIX && budget > 0) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? phase : 1'($urandom_range(0, 1));
            phase = !phase;
            cycle(v, pix_at(base, acc_n - n0), rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            budget--;
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL frame_timeout: accepted %0d want %0d", acc_n - n0, NPIX);
        end
        if (drain) repeat (4) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.pix_valid_i = 1'b0;
        io.pix_i = '0;
        io.win_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (io.win_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", io.win_valid_o); end
        total++; if (io.frame_done_o !== 1'b0) begin bad++; $display("FAIL reset_fdone: got %b want 0", io.frame_done_o); end
        total++; if (cur_win() !== 72'h0) begin bad++; $display("FAIL reset_win: got %h want 0", cur_win()); end
        total++; if (io.pix_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", io.pix_ready_o); end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_basic();
        clear_log();
        send_frame(8'h00, 0, 1'b0, 1'b1);
        total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), NWIN); end
        for (int i = 0; i < NWIN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== model_win(8'h00, i)) begin bad++; $display("FAIL basic_win%0d: got %h want %h", i, got_q[i], model_win(8'h00, i)); end
        end
        if (got_q.size() >= 2) begin
            total++; if (got_q[0] !== 72'h000102101112202122) begin bad++; $display("FAIL basic_first: got %h want 000102101112202122", got_q[0]); end
            total++; if (got_q[1] !== 72'h010203111213212223) begin bad++; $display("FAIL basic_second: got %h want 010203111213212223", got_q[1]); end
            total++; if (got_cyc[1] != got_cyc[0] + 1) begin bad++; $display("FAIL basic_throughput: gap %0d want 1", got_cyc[1] - got_cyc[0]); end
        end
        total++; if (first_win_cyc != acc_cyc[10] + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d", first_win_cyc - acc_cyc[10], 1); end
        total++; if (fd_cyc.size() != 1) begin bad++; $display("FAIL basic_fd_count: got %0d want 1", fd_cyc.size()); end
        else begin
            total++; if (fd_cyc[0] != acc_cyc[NPIX-1] + 1) begin bad++; $display("FAIL basic_fd_time: got %0d want %0d", fd_cyc[0], acc_cyc[NPIX-1] + 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] held;
        bit stalled;
        int budget;
        clear_log();
        stalled = 1'b0;
        budget = 200;
        while (acc_n < NPIX && budget > 0) begin
            if (io.win_valid_o && !stalled) begin
                stalled = 1'b1;
                held = cur_win();
                total++; if (held !== model_win(8'h00, 0)) begin bad++; $display("FAIL bp_first: got %h want %h", held, model_win(8'h00, 0)); end
                for (int k = 0; k < 5; k++) begin
                    io.pix_valid_i = 1'b1;
                    io.pix_i = pix_at(8'h00, acc_n);
                    io.win_ready_i = 1'b0;
                    #1;
                    total++; if (io.pix_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b want 0", k, io.pix_ready_o); end
                    total++; if (cur_win() !== held || io.win_valid_o !== 1'b1) begin bad++; $display("FAIL bp_hold%0d: got %h/%b want %h/1", k, cur_win(), io.win_valid_o, held); end
                    @(negedge clk);
                    cyc++;
                end
            end
            cycle(1'b1, pix_at(8'h00, acc_n), 1'b1);
            budget--;
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), NWIN); end
        for (int i = 0; i < NWIN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== model_win(8'h00, i)) begin bad++; $display("FAIL bp_win%0d: got %h want %h", i, got_q[i], model_win(8'h00, i)); end
        end
    endtask

    task automatic test_gaps();
        int emit_idx [4];
        emit_idx = '{10, 11, 14, 15};
        clear_log();
        send_frame(8'h00, 1, 1'b0, 1'b1);
        total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL gap_count: got %0d want %0d", got_q.size(), NWIN); end
        for (int i = 0; i < NWIN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== model_win(8'h00, i) || got_cyc[i] != acc_cyc[emit_idx[i]] + 1)
                begin bad++; $display("FAIL gap_win%0d: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], model_win(8'h00, i), acc_cyc[emit_idx[i]] + 1); end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'h00, 0, 1'b0, 1'b0);
        send_frame(8'h80, 0, 1'b0, 1'b1);
        total++; if (got_q.size() != 2 * NWIN) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 2 * NWIN); end
        for (int i = 0; i < 2 * NWIN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== model_win(i < NWIN ? 8'h00 : 8'h80, i % NWIN))
                begin bad++; $display("FAIL b2b_win%0d: got %h want %h", i, got_q[i], model_win(i < NWIN ? 8'h00 : 8'h80, i % NWIN)); end
        end
        if (got_q.size() > NWIN) begin
            total++; if (got_q[NWIN] !== 72'h808182909192A0A1A2) begin bad++; $display("FAIL b2b_first2: got %h want 808182909192a0a1a2", got_q[NWIN]); end
            total++; if (got_cyc[NWIN] != acc_cyc[NPIX + 10] + 1) begin bad++; $display("FAIL b2b_first2_time: got %0d want %0d", got_cyc[NWIN], acc_cyc[NPIX + 10] + 1); end
        end
        total++; if (fd_cyc.size() != 2) begin bad++; $display("FAIL b2b_fd_count: got %0d want 2", fd_cyc.size()); end
    endtask

    task automatic test_drain_load();
        clear_log();
        while (acc_n < 11) cycle(1'b1, pix_at(8'h00, acc_n), 1'b1);
        total++; if (io.win_valid_o !== 1'b1 || cur_win() !== model_win(8'h00, 0))
            begin bad++; $display("FAIL dl_pre: got %h/%b want %h/1", cur_win(), io.win_valid_o, model_win(8'h00, 0)); end
        cycle(1'b1, pix_at(8'h00, 11), 1'b1);
        total++; if (io.win_valid_o !== 1'b1 || cur_win() !== model_win(8'h00, 1))
            begin bad++; $display("FAIL dl_post: got %h/%b want %h/1", cur_win(), io.win_valid_o, model_win(8'h00, 1)); end
        while (acc_n < NPIX) cycle(1'b1, pix_at(8'h00, acc_n), 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid();
        clear_log();
        while (acc_n < 12) cycle(1'b1, pix_at(8'h00, acc_n), 1'b1);
        total++; if (io.win_valid_o !== 1'b1) begin bad++; $display("FAIL rm_pending: got %b want 1", io.win_valid_o); end
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        total++; if (io.win_valid_o !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", io.win_valid_o); end
        total++; if (io.frame_done_o !== 1'b0) begin bad++; $display("FAIL rm_fdone: got %b want 0", io.frame_done_o); end
        rst = 1'b0;
        clear_log();
        send_frame(8'h40, 0, 1'b0, 1'b1);
        total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL rm_count: got %0d want %0d", got_q.size(), NWIN); end
        for (int i = 0; i < NWIN && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== model_win(8'h40, i)) begin bad++; $display("FAIL rm_win%0d: got %h want %h", i, got_q[i], model_win(8'h40, i)); end
        end
        total++; if (fd_cyc.size() != 1) begin bad++; $display("FAIL rm_fd_count: got %0d want 1", fd_cyc.size()); end
    endtask

    task automatic test_random();
        logic [7:0] base;
        for (int f = 0; f < 4; f++) begin
            clear_log();
            base = 8'($urandom);
            send_frame(base, 2, 1'b1, 1'b1);
            total++; if (got_q.size() != NWIN) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", f, got_q.size(), NWIN); end
            for (int i = 0; i < NWIN && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== model_win(base, i)) begin bad++; $display("FAIL rnd%0d_win%0d: got %h want %h", f, i, got_q[i], model_win(base, i)); end
            end
            total++; if (fd_cyc.size() != 1) begin bad++; $display("FAIL rnd%0d_fd_count: got %0d want 1", f, fd_cyc.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_drain_load();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
